// File: rtl/tlb_write_ctl_pkg.sv
// Shared encodings and widths for the TLB write controller.
package tlb_write_ctl_pkg;

    localparam int         TLB_IDX_W       = 8;
    localparam int         TLB_TAG_W       = 16;
    localparam logic [7:0] TIMEOUT_DEFAULT = 8'd255;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DRAIN     = 3'd1,
        ST_ASSERT    = 3'd2,
        ST_WAIT_RISE = 3'd3,
        ST_WAIT_DONE = 3'd4
    } tlb_state_e;

    // Byte address of a TLB entry: one 32-bit word per index.
    function automatic logic [31:0] tlb_entry_addr(input logic [TLB_IDX_W-1:0] idx);
        return {22'b0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/tlb_write_ctl_if.sv
// TLB-write command channel: request handshake plus completion/timeout pulses.
interface tlb_write_ctl_if;
    import tlb_write_ctl_pkg::*;

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [TLB_IDX_W-1:0] cmd_index;
    logic [TLB_TAG_W-1:0] cmd_ptag;
    logic [TLB_TAG_W-1:0] cmd_vtag;
    logic                 cmd_done;
    logic                 cmd_err;

    modport master (
        output cmd_valid, cmd_index, cmd_ptag, cmd_vtag,
        input  cmd_ready, cmd_done, cmd_err
    );

    modport slave (
        input  cmd_valid, cmd_index, cmd_ptag, cmd_vtag,
        output cmd_ready, cmd_done, cmd_err
    );

endinterface

// File: rtl/tlb_fault_capture.sv
// Registered MMU fault qualification; FAULT_CAPTURE_EN selects sticky capture with
// address latch, otherwise a one-cycle interrupt per fault.
module tlb_fault_capture (
    input  logic        CPU_CLK,
    input  logic        RST,
    input  logic        MMU_FAULT,
    input  logic        acc_valid,
    input  logic [31:0] cycle_addr,
    input  logic        fsm_idle_i,
    input  logic        fault_ack,
    output logic        fault_irq,
    output logic [31:0] fault_addr
);
    logic fault_q;
    logic fault_v;

    always_ff @(posedge CPU_CLK) begin
        if (!RST) fault_q <= 1'b0;
        else      fault_q <= MMU_FAULT & acc_valid;
    end

    // TLB contents are in flux outside IDLE, so faults seen then are dropped.
    assign fault_v = fault_q & fsm_idle_i;

`ifdef FAULT_CAPTURE_EN
    logic [31:0] addr_q;
    logic [31:0] hold_q, hold_d;
    logic        pend_q, pend_d;

    always_comb begin
        pend_d = pend_q;
        hold_d = hold_q;
        if (fault_ack) pend_d = 1'b0;
        // A fault landing with the ack re-arms pending with the new address.
        if (fault_v && (!pend_q || fault_ack)) begin
            pend_d = 1'b1;
            hold_d = addr_q;
        end
    end

    always_ff @(posedge CPU_CLK) begin
        if (!RST) begin
            addr_q <= '0;
            hold_q <= '0;
            pend_q <= 1'b0;
        end else begin
            addr_q <= cycle_addr;
            hold_q <= hold_d;
            pend_q <= pend_d;
        end
    end

    assign fault_irq  = pend_q | fault_v;
    assign fault_addr = pend_q ? hold_q : (fault_v ? addr_q : 32'h0);
`else
    logic unused_ok;
    assign unused_ok  = &{1'b0, fault_ack, cycle_addr};
    assign fault_irq  = fault_v;
    assign fault_addr = 32'h0;
`endif

endmodule

// File: rtl/tlb_write_ctl.sv
// TLB write controller: drains CPU data writes, strobes WE_TLB for two cycles and
// tracks the cache busy handshake with a timeout. Build option: FAULT_CAPTURE_EN.
module tlb_write_ctl
    import tlb_write_ctl_pkg::*;
#(
    parameter logic [7:0] TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic           CPU_CLK,
    input  logic           RST,
    tlb_write_ctl_if.slave cmd,
    input  logic           cpu_we_in,
    output logic           cpu_we_out,
    output logic           cpu_stall,
    output logic           WE_TLB,
    output logic [31:0]    tlb_addr,
    output logic [31:0]    tlb_datao,
    input  logic           TLB_write_busy,
    input  logic           MMU_FAULT,
    input  logic           acc_valid,
    input  logic [31:0]    cycle_addr,
    output logic           fault_irq,
    output logic [31:0]    fault_addr,
    input  logic           fault_ack
);
    tlb_state_e           state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [TLB_IDX_W-1:0] idx_q;
    logic [TLB_TAG_W-1:0] ptag_q, vtag_q;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 latch_en;

    always_ff @(posedge CPU_CLK) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            ptag_q  <= '0;
            vtag_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (latch_en) begin
                idx_q  <= cmd.cmd_index;
                ptag_q <= cmd.cmd_ptag;
                vtag_q <= cmd.cmd_vtag;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        done_d        = 1'b0;
        err_d         = 1'b0;
        latch_en      = 1'b0;
        cmd.cmd_ready = 1'b0;
        cpu_stall     = 1'b1;
        cpu_we_out    = 1'b0;
        WE_TLB        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd.cmd_ready = 1'b1;
                cpu_stall     = 1'b0;
                cpu_we_out    = cpu_we_in;
                cnt_d         = '0;
                if (cmd.cmd_valid) begin
                    latch_en = 1'b1;
                    state_d  = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!cpu_we_in) state_d = ST_ASSERT;
            end
            ST_ASSERT: begin
                // Two cycles wide so the slower memory clock is sure to sample it.
                WE_TLB = 1'b1;
                if (cnt_q[0]) begin
                    state_d = ST_WAIT_RISE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_WAIT_RISE: begin
                if (TLB_write_busy || cnt_q[0]) begin
                    state_d = ST_WAIT_DONE;
                    cnt_d   = 8'd1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_WAIT_DONE: begin
                // cnt_q is the 1-based cycle count inside WAIT_DONE.
                if (!TLB_write_busy) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign cmd.cmd_done = done_q;
    assign cmd.cmd_err  = err_q;
    assign tlb_addr     = tlb_entry_addr(idx_q);
    assign tlb_datao    = {ptag_q, vtag_q};

    tlb_fault_capture u_fault (
        .CPU_CLK    (CPU_CLK),
        .RST        (RST),
        .MMU_FAULT  (MMU_FAULT),
        .acc_valid  (acc_valid),
        .cycle_addr (cycle_addr),
        .fsm_idle_i (state_q == ST_IDLE),
        .fault_ack  (fault_ack),
        .fault_irq  (fault_irq),
        .fault_addr (fault_addr)
    );

endmodule

// File: tb/tb_tlb_write_ctl.sv
// Randomized bench for tlb_write_ctl: timeline model of the write sequence plus a
// fault-capture model that follows FAULT_CAPTURE_EN.
`timescale 1ns/1ps
module tb_tlb_write_ctl;
    import tlb_write_ctl_pkg::*;

    localparam int TMO = 255;

    logic        CPU_CLK = 1'b0;
    logic        RST;
    logic        cpu_we_in, cpu_we_out, cpu_stall, WE_TLB;
    logic        TLB_write_busy, MMU_FAULT, acc_valid, fault_irq, fault_ack;
    logic [31:0] tlb_addr, tlb_datao, cycle_addr, fault_addr;

    int n_cmp = 0;
    int n_bad = 0;

    // Observations of the last run_cmd, and the model's expectations for it.
    int o_we_first, o_we_cnt, o_done_cyc, o_done_cnt, o_err_cyc, o_err_cnt;
    int o_viol, o_lat_bad, o_irq_cnt;
    int e_we_first, e_pulse;
    bit e_err;

    tlb_write_ctl_if cmd_if ();

    tlb_write_ctl dut (
        .CPU_CLK        (CPU_CLK),
        .RST            (RST),
        .cmd            (cmd_if),
        .cpu_we_in      (cpu_we_in),
        .cpu_we_out     (cpu_we_out),
        .cpu_stall      (cpu_stall),
        .WE_TLB         (WE_TLB),
        .tlb_addr       (tlb_addr),
        .tlb_datao      (tlb_datao),
        .TLB_write_busy (TLB_write_busy),
        .MMU_FAULT      (MMU_FAULT),
        .acc_valid      (acc_valid),
        .cycle_addr     (cycle_addr),
        .fault_irq      (fault_irq),
        .fault_addr     (fault_addr),
        .fault_ack      (fault_ack)
    );

    always #5 CPU_CLK = ~CPU_CLK;

    // Busy window: rises r cycles after WE_TLB first rises, lasts len cycles (len<0: forever).
    function automatic bit busy_at(input int t, input int w0, input int r, input int len);
        return (t >= w0 + r) && (len < 0 || t < w0 + r + len);
    endfunction

    // Timeline in cycles from the accept cycle (0): cpu_we_in high for cycles 1..d.
    task automatic model(input int d, input int r, input int len,
                         output int w0, output int pulse, output bit is_err);
        int e;
        w0 = d + 2;
        // Post-strobe wait lasts one cycle if busy is already up, else two.
        e = busy_at(w0 + 2, w0, r, len) ? w0 + 3 : w0 + 4;
        pulse  = e + TMO;
        is_err = 1'b1;
        for (int t = e; t < e + TMO; t++) begin
            if (!busy_at(t, w0, r, len)) begin
                pulse  = t + 1;
                is_err = 1'b0;
                break;
            end
        end
    endtask

    task automatic run_cmd(input int d, input int r, input int len, input logic [7:0] idx,
                           input logic [15:0] pt, input logic [15:0] vt, input bit noise);
        int  w0, pulse;
        bit  is_err, exp_idle;
        model(d, r, len, w0, pulse, is_err);
        e_we_first = w0; e_pulse = pulse; e_err = is_err;
        o_we_first = -1; o_we_cnt = 0; o_done_cyc = -1; o_done_cnt = 0;
        o_err_cyc = -1; o_err_cnt = 0; o_viol = 0; o_lat_bad = 0; o_irq_cnt = 0;
        for (int t = 0; t <= pulse + 3; t++) begin
            cmd_if.cmd_valid = (t == 0) || (noise && t < pulse - 1 && $urandom_range(1) == 1);
            cmd_if.cmd_index = (t == 0) ? idx : 8'($urandom);
            cmd_if.cmd_ptag  = (t == 0) ? pt  : 16'($urandom);
            cmd_if.cmd_vtag  = (t == 0) ? vt  : 16'($urandom);
            if (t >= 1 && t <= d)  cpu_we_in = 1'b1;
            else if (t == d + 1)   cpu_we_in = 1'b0;
            else                   cpu_we_in = 1'($urandom);
            TLB_write_busy = busy_at(t, w0, r, len);
            MMU_FAULT  = noise && t <= pulse - 2 && 1'($urandom);
            acc_valid  = noise && 1'($urandom);
            cycle_addr = $urandom;
            @(negedge CPU_CLK);
            if (WE_TLB) begin
                if (o_we_first < 0) o_we_first = t;
                o_we_cnt++;
            end
            if (WE_TLB && cpu_we_out) o_viol++;
            if (cmd_if.cmd_done) begin if (o_done_cyc < 0) o_done_cyc = t; o_done_cnt++; end
            if (cmd_if.cmd_err)  begin if (o_err_cyc < 0)  o_err_cyc = t;  o_err_cnt++;  end
            exp_idle = !(t > 0 && t < pulse);
            if (cpu_stall !== !exp_idle || cmd_if.cmd_ready !== exp_idle ||
                cpu_we_out !== (exp_idle ? cpu_we_in : 1'b0)) o_viol++;
            if (t > 0 && (tlb_addr !== {22'b0, idx, 2'b00} || tlb_datao !== {pt, vt})) o_lat_bad++;
            if (t >= 1 && t < pulse && fault_irq) o_irq_cnt++;
            @(posedge CPU_CLK); #1;
        end
        cmd_if.cmd_valid = 1'b0; cpu_we_in = 1'b0; TLB_write_busy = 1'b0;
        MMU_FAULT = 1'b0; acc_valid = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        cmd_if.cmd_valid = 1'b0; cmd_if.cmd_index = '0; cmd_if.cmd_ptag = '0; cmd_if.cmd_vtag = '0;
        cpu_we_in = 1'b0; TLB_write_busy = 1'b0; MMU_FAULT = 1'b0; acc_valid = 1'b0;
        cycle_addr = '0; fault_ack = 1'b0;
        repeat (3) @(posedge CPU_CLK);
        #1;
        @(negedge CPU_CLK);
        n_cmp++; if (WE_TLB !== 1'b0) begin n_bad++; $display("FAIL reset_we_tlb got %b want 0", WE_TLB); end
        n_cmp++; if (cpu_stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %b want 0", cpu_stall); end
        n_cmp++; if (cmd_if.cmd_done !== 1'b0 || cmd_if.cmd_err !== 1'b0) begin n_bad++; $display("FAIL reset_pulses got done=%b err=%b want 0/0", cmd_if.cmd_done, cmd_if.cmd_err); end
        n_cmp++; if (cmd_if.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", cmd_if.cmd_ready); end
        n_cmp++; if (fault_irq !== 1'b0 || fault_addr !== 32'h0) begin n_bad++; $display("FAIL reset_fault got irq=%b addr=%h want 0/0", fault_irq, fault_addr); end
        n_cmp++; if (tlb_addr !== 32'h0 || tlb_datao !== 32'h0) begin n_bad++; $display("FAIL reset_latch got %h/%h want 0/0", tlb_addr, tlb_datao); end
        @(posedge CPU_CLK); #1;
        RST = 1'b1;
        @(posedge CPU_CLK); #1;
    endtask

    task automatic test_handshake();
        run_cmd(0, 1, 6, 8'h2A, 16'h1234, 16'h00C3, 1'b0);
        n_cmp++; if (o_we_first !== e_we_first) begin n_bad++; $display("FAIL hs_we_rise got %0d want %0d", o_we_first, e_we_first); end
        n_cmp++; if (o_we_cnt !== 2) begin n_bad++; $display("FAIL hs_we_width got %0d want 2", o_we_cnt); end
        n_cmp++; if (o_done_cyc !== 10 || o_done_cnt !== 1) begin n_bad++; $display("FAIL hs_done got cyc=%0d cnt=%0d want 10/1", o_done_cyc, o_done_cnt); end
        n_cmp++; if (o_err_cnt !== 0) begin n_bad++; $display("FAIL hs_no_err got %0d want 0", o_err_cnt); end
        n_cmp++; if (o_viol !== 0) begin n_bad++; $display("FAIL hs_ctl_outputs got %0d bad cycles want 0", o_viol); end
        n_cmp++; if (tlb_addr !== 32'h000000A8) begin n_bad++; $display("FAIL hs_addr got %h want 000000a8", tlb_addr); end
        n_cmp++; if (tlb_datao !== 32'h123400C3) begin n_bad++; $display("FAIL hs_data got %h want 123400c3", tlb_datao); end
        n_cmp++; if (o_lat_bad !== 0) begin n_bad++; $display("FAIL hs_latch_hold got %0d bad cycles want 0", o_lat_bad); end
    endtask

    task automatic test_drain();
        run_cmd(3, 1, 4, 8'h11, 16'hBEEF, 16'h0101, 1'b0);
        n_cmp++; if (o_we_first !== 5) begin n_bad++; $display("FAIL drain_we_rise got %0d want 5", o_we_first); end
        n_cmp++; if (o_viol !== 0) begin n_bad++; $display("FAIL drain_overlap got %0d bad cycles want 0", o_viol); end
        n_cmp++; if (o_done_cyc !== e_pulse || o_done_cnt !== 1) begin n_bad++; $display("FAIL drain_done got cyc=%0d cnt=%0d want %0d/1", o_done_cyc, o_done_cnt, e_pulse); end
    endtask

    task automatic test_timeout();
        run_cmd($urandom_range(0, 2), 1, -1, 8'hF0, 16'h7777, 16'h8888, 1'b0);
        n_cmp++; if (o_err_cyc !== e_pulse || o_err_cnt !== 1) begin n_bad++; $display("FAIL tmo_err got cyc=%0d cnt=%0d want %0d/1", o_err_cyc, o_err_cnt, e_pulse); end
        n_cmp++; if (e_pulse - e_we_first - 3 !== TMO) begin n_bad++; $display("FAIL tmo_model_span got %0d want %0d", e_pulse - e_we_first - 3, TMO); end
        n_cmp++; if (o_done_cnt !== 0) begin n_bad++; $display("FAIL tmo_no_done got %0d want 0", o_done_cnt); end
        n_cmp++; if (o_viol !== 0) begin n_bad++; $display("FAIL tmo_return_idle got %0d bad cycles want 0", o_viol); end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_index = 8'h55;
        cmd_if.cmd_ptag = 16'hAAAA; cmd_if.cmd_vtag = 16'h5555;
        cpu_we_in = 1'b0; TLB_write_busy = 1'b0;
        @(posedge CPU_CLK); #1;
        cmd_if.cmd_valid = 1'b0;
        @(posedge CPU_CLK); #1;
        @(negedge CPU_CLK);
        n_cmp++; if (WE_TLB !== 1'b1) begin n_bad++; $display("FAIL mid_in_assert got %b want 1", WE_TLB); end
        RST = 1'b0;
        @(posedge CPU_CLK); #1;
        @(negedge CPU_CLK);
        n_cmp++; if (WE_TLB !== 1'b0 || cpu_stall !== 1'b0) begin n_bad++; $display("FAIL mid_abort got we=%b stall=%b want 0/0", WE_TLB, cpu_stall); end
        n_cmp++; if (tlb_addr !== 32'h0) begin n_bad++; $display("FAIL mid_latch_clr got %h want 0", tlb_addr); end
        RST = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge CPU_CLK); #1;
            TLB_write_busy = 1'($urandom);
            @(negedge CPU_CLK);
            if (cmd_if.cmd_done || cmd_if.cmd_err || WE_TLB) pulses++;
        end
        @(posedge CPU_CLK); #1;
        TLB_write_busy = 1'b0;
        n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL mid_no_pulse got %0d want 0", pulses); end
        run_cmd(1, 0, 3, 8'h3C, 16'h4321, 16'h8765, 1'b0);
        n_cmp++; if (o_done_cyc !== e_pulse || o_done_cnt !== 1) begin n_bad++; $display("FAIL mid_recover got cyc=%0d cnt=%0d want %0d/1", o_done_cyc, o_done_cnt, e_pulse); end
    endtask

    task automatic test_random_writes();
        for (int k = 0; k < 20; k++) begin
            run_cmd($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 12),
                    8'($urandom), 16'($urandom), 16'($urandom), 1'b1);
            n_cmp++; if (o_we_first !== e_we_first || o_we_cnt !== 2) begin n_bad++; $display("FAIL rnd%0d_we got first=%0d cnt=%0d want %0d/2", k, o_we_first, o_we_cnt, e_we_first); end
            n_cmp++; if (o_done_cyc !== e_pulse || o_done_cnt !== 1 || o_err_cnt !== 0) begin n_bad++; $display("FAIL rnd%0d_done got cyc=%0d cnt=%0d err=%0d want %0d/1/0", k, o_done_cyc, o_done_cnt, o_err_cnt, e_pulse); end
            n_cmp++; if (o_viol !== 0 || o_lat_bad !== 0) begin n_bad++; $display("FAIL rnd%0d_ctl got viol=%0d lat=%0d want 0/0", k, o_viol, o_lat_bad); end
            n_cmp++; if (o_irq_cnt !== 0) begin n_bad++; $display("FAIL rnd%0d_busy_fault got %0d irq cycles want 0", k, o_irq_cnt); end
        end
    endtask

    task automatic test_fault_basic();
        MMU_FAULT = 1'b1; acc_valid = 1'b1; cycle_addr = 32'hDEAD0004;
        @(posedge CPU_CLK); #1;
        MMU_FAULT = 1'b0; cycle_addr = 32'h0;
        @(negedge CPU_CLK);
`ifdef FAULT_CAPTURE_EN
        n_cmp++; if (fault_irq !== 1'b1 || fault_addr !== 32'hDEAD0004) begin n_bad++; $display("FAIL flt_first got irq=%b addr=%h want 1/dead0004", fault_irq, fault_addr); end
        @(posedge CPU_CLK); #1;
        MMU_FAULT = 1'b1; cycle_addr = 32'h00001000;
        @(posedge CPU_CLK); #1;
        MMU_FAULT = 1'b0;
        @(posedge CPU_CLK); #1;
        @(negedge CPU_CLK);
        n_cmp++; if (fault_irq !== 1'b1 || fault_addr !== 32'hDEAD0004) begin n_bad++; $display("FAIL flt_second got irq=%b addr=%h want 1/dead0004", fault_irq, fault_addr); end
        @(posedge CPU_CLK); #1;
        MMU_FAULT = 1'b1; cycle_addr = 32'h00002000; fault_ack = 1'b1;
        @(posedge CPU_CLK); #1;
        MMU_FAULT = 1'b0; fault_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge CPU_CLK);
            n_cmp++; if (fault_irq !== 1'b1 || fault_addr !== 32'h00002000) begin n_bad++; $display("FAIL flt_ack_reload%0d got irq=%b addr=%h want 1/00002000", i, fault_irq, fault_addr); end
            @(posedge CPU_CLK); #1;
        end
        fault_ack = 1'b1;
        @(posedge CPU_CLK); #1;
        fault_ack = 1'b0;
        @(negedge CPU_CLK);
        n_cmp++; if (fault_irq !== 1'b0) begin n_bad++; $display("FAIL flt_ack_clear got %b want 0", fault_irq); end
`else
        n_cmp++; if (fault_irq !== 1'b1 || fault_addr !== 32'h0) begin n_bad++; $display("FAIL flt_pulse got irq=%b addr=%h want 1/0", fault_irq, fault_addr); end
        @(posedge CPU_CLK); #1;
        MMU_FAULT = 1'b1; acc_valid = 1'b0;
        @(negedge CPU_CLK);
        n_cmp++; if (fault_irq !== 1'b0) begin n_bad++; $display("FAIL flt_one_cycle got %b want 0", fault_irq); end
        @(posedge CPU_CLK); #1;
        MMU_FAULT = 1'b0;
        @(negedge CPU_CLK);
        n_cmp++; if (fault_irq !== 1'b0) begin n_bad++; $display("FAIL flt_unqualified got %b want 0", fault_irq); end
`endif
        @(posedge CPU_CLK); #1;
        MMU_FAULT = 1'b0; acc_valid = 1'b0; fault_ack = 1'b0;
    endtask

    task automatic test_fault_random();
        bit          pend = 1'b0, ev, raw_prev = 1'b0, exp_irq;
        logic [31:0] hold = '0, addr_prev = '0;
        int          bad_irq = 0, bad_addr = 0;
        for (int t = 0; t < 200; t++) begin
            MMU_FAULT  = ($urandom_range(2) == 0);
            acc_valid  = 1'($urandom);
            fault_ack  = ($urandom_range(3) == 0);
            cycle_addr = $urandom;
            ev = raw_prev;
            @(negedge CPU_CLK);
`ifdef FAULT_CAPTURE_EN
            exp_irq = pend | ev;
            if (pend && fault_addr !== hold) bad_addr++;
            if (ev && (!pend || fault_ack)) begin pend = 1'b1; hold = addr_prev; end
            else if (fault_ack) pend = 1'b0;
`else
            exp_irq = ev;
            if (fault_addr !== 32'h0) bad_addr++;
`endif
            if (fault_irq !== exp_irq) bad_irq++;
            raw_prev  = MMU_FAULT & acc_valid;
            addr_prev = cycle_addr;
            @(posedge CPU_CLK); #1;
        end
        MMU_FAULT = 1'b0; acc_valid = 1'b0; fault_ack = 1'b0;
        n_cmp++; if (bad_irq !== 0) begin n_bad++; $display("FAIL frnd_irq got %0d bad cycles want 0", bad_irq); end
        n_cmp++; if (bad_addr !== 0) begin n_bad++; $display("FAIL frnd_addr got %0d bad cycles want 0", bad_addr); end
    endtask

    initial begin
        test_reset();
        test_handshake();
        test_drain();
        test_timeout();
        test_reset_mid();
        test_random_writes();
        test_fault_basic();
        test_fault_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
